// File: rtl/dmover_multich_rd_if.sv
// Stream bundle between the tile reader, the datamover and the array.
// master = tile reader side, slave = environment side.
interface dmover_multich_rd_if #(
  parameter int DATA_W = 128,
  parameter int CMD_W  = 72
);
  logic [31:0]         s_axis_dmrconfig_tdata;
  logic                s_axis_dmrconfig_tvalid;
  logic                s_axis_dmrconfig_tready;
  logic [CMD_W-1:0]    m_axis_mm2s_cmd_tdata;
  logic                m_axis_mm2s_cmd_tvalid;
  logic                m_axis_mm2s_cmd_tready;
  logic [DATA_W-1:0]   s_axis_mm2s_tdata;
  logic                s_axis_mm2s_tvalid;
  logic                s_axis_mm2s_tready;
  logic [7:0]          s_axis_mm2s_sts_tdata;
  logic                s_axis_mm2s_sts_tvalid;
  logic                s_axis_mm2s_sts_tready;
  logic [DATA_W-1:0]   m_axis_dmr_tdata;
  logic                m_axis_dmr_tvalid;
  logic                m_axis_dmr_tready;
  logic                m_axis_dmr_tlast;
  logic [DATA_W/8-1:0] m_axis_dmr_tkeep;

  modport master (
    input  s_axis_dmrconfig_tdata, s_axis_dmrconfig_tvalid,
    output s_axis_dmrconfig_tready,
    output m_axis_mm2s_cmd_tdata, m_axis_mm2s_cmd_tvalid,
    input  m_axis_mm2s_cmd_tready,
    input  s_axis_mm2s_tdata, s_axis_mm2s_tvalid,
    output s_axis_mm2s_tready,
    input  s_axis_mm2s_sts_tdata, s_axis_mm2s_sts_tvalid,
    output s_axis_mm2s_sts_tready,
    output m_axis_dmr_tdata, m_axis_dmr_tvalid,
    input  m_axis_dmr_tready,
    output m_axis_dmr_tlast, m_axis_dmr_tkeep
  );

  modport slave (
    output s_axis_dmrconfig_tdata, s_axis_dmrconfig_tvalid,
    input  s_axis_dmrconfig_tready,
    input  m_axis_mm2s_cmd_tdata, m_axis_mm2s_cmd_tvalid,
    output m_axis_mm2s_cmd_tready,
    output s_axis_mm2s_tdata, s_axis_mm2s_tvalid,
    input  s_axis_mm2s_tready,
    output s_axis_mm2s_sts_tdata, s_axis_mm2s_sts_tvalid,
    input  s_axis_mm2s_sts_tready,
    input  m_axis_dmr_tdata, m_axis_dmr_tvalid,
    output m_axis_dmr_tready,
    input  m_axis_dmr_tlast, m_axis_dmr_tkeep
  );
endinterface

// File: rtl/dmover_multich_rd.sv
// Multi-channel tile reader: issues one MM2S command per tile row.
// Define DMR_ROW_TLAST_EN to mark tlast on every row instead of job end.
module dmover_multich_rd #(
  parameter int DATA_W = 128,
  parameter int CMD_W  = 72
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmover_multich_rd_if.master  bus,
  output logic [2:0]           status_dmr,
  output logic                 err_dmr
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CFG  = 3'b001,
    CALC = 3'b011,
    CMD  = 3'b010,
    RD   = 3'b110,
    NEXT = 3'b111,
    DONE = 3'b100
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  widx_q, widx_d;
  logic [15:0] chin_q, chin_d;
  logic [7:0]  wtile_q, wtile_d;
  logic [11:0] imgh_q, imgh_d;
  logic [11:0] imgw_q, imgw_d;
  logic [31:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [22:0] au_q, au_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] taddr_q, taddr_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  tile_q, tile_d;
  logic [11:0] row_q, row_d;
  logic [15:0] beat_q, beat_d;
  logic [3:0]  tag_q, tag_d;
  logic        err_q, err_d;

  logic        in_cfg, in_cmd, in_rd;
  logic        cfg_hs, cmd_hs, beat_hs, sts_err;
  logic        last_row, last_tile, last_beat, row_end;
  logic [15:0] len_c;
  logic [22:0] au_c;
  logic [31:0] rs_c;
  logic        unused_ok;

  assign in_cfg = (state_q == CFG);
  assign in_cmd = (state_q == CMD);
  assign in_rd  = (state_q == RD);

  assign cfg_hs  = in_cfg & bus.s_axis_dmrconfig_tvalid;
  assign cmd_hs  = in_cmd & bus.m_axis_mm2s_cmd_tready;
  assign beat_hs = in_rd & bus.s_axis_mm2s_tvalid
                 & bus.m_axis_dmr_tready;
  assign sts_err = bus.s_axis_mm2s_sts_tvalid
                 & (|bus.s_axis_mm2s_sts_tdata[6:4]);

  assign len_c = 16'(32'(imgw_q) * 32'(chin_q >> 3));
  assign au_c  = 23'(32'(imgw_q) * {15'd0, chin_q, 1'b0});
  assign rs_c  = 32'(au_c) * 32'(wtile_q);

  assign last_row  = (row_q == imgh_q - 12'd1);
  assign last_tile = (tile_q == wtile_q - 8'd1);
  assign last_beat = (beat_q == len_q - 16'd1);

`ifdef DMR_ROW_TLAST_EN
  assign row_end = last_beat;
`else
  assign row_end = last_beat & last_row & last_tile;
`endif

  assign bus.s_axis_dmrconfig_tready = in_cfg;
  assign bus.m_axis_mm2s_cmd_tvalid  = in_cmd;
  assign bus.m_axis_mm2s_cmd_tdata   = in_cmd
    ? CMD_W'({4'h0, tag_q, raddr_q, 1'b0, 1'b1,
              6'h00, 1'b1, au_q})
    : '0;
  assign bus.s_axis_mm2s_tready  = in_rd & bus.m_axis_dmr_tready;
  assign bus.m_axis_dmr_tvalid   = in_rd & bus.s_axis_mm2s_tvalid;
  assign bus.m_axis_dmr_tdata    = in_rd ? bus.s_axis_mm2s_tdata : '0;
  assign bus.m_axis_dmr_tlast    = in_rd & row_end;
  assign bus.m_axis_dmr_tkeep    = {(DATA_W/8){1'b1}};
  assign bus.s_axis_mm2s_sts_tready = 1'b1;

  assign status_dmr = state_q;
  assign err_dmr    = err_q;

  assign unused_ok = ^{bus.s_axis_mm2s_sts_tdata[7],
                       bus.s_axis_mm2s_sts_tdata[3:0]};

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    chin_d  = chin_q;
    wtile_d = wtile_q;
    imgh_d  = imgh_q;
    imgw_d  = imgw_q;
    base_d  = base_q;
    len_d   = len_q;
    au_d    = au_q;
    rs_d    = rs_q;
    taddr_d = taddr_q;
    raddr_d = raddr_q;
    tile_d  = tile_q;
    row_d   = row_q;
    beat_d  = beat_q;
    tag_d   = tag_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: state_d = CFG;
      CFG: if (cfg_hs) begin
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd0) begin
          chin_d  = bus.s_axis_dmrconfig_tdata[31:16];
          wtile_d = bus.s_axis_dmrconfig_tdata[15:8];
          err_d   = 1'b0;
        end else if (widx_q == 2'd1) begin
          imgh_d = bus.s_axis_dmrconfig_tdata[23:12];
          imgw_d = bus.s_axis_dmrconfig_tdata[11:0];
        end else begin
          base_d  = bus.s_axis_dmrconfig_tdata;
          widx_d  = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        len_d   = len_c;
        au_d    = au_c;
        rs_d    = rs_c;
        taddr_d = base_q;
        raddr_d = base_q;
        tile_d  = 8'd0;
        row_d   = 12'd0;
        beat_d  = 16'd0;
        tag_d   = 4'd0;
        if (wtile_q == 8'd0 || imgh_q == 12'd0 || len_c == 16'd0)
          state_d = DONE;
        else
          state_d = CMD;
      end
      CMD: if (cmd_hs) begin
        tag_d   = tag_q + 4'd1;
        state_d = RD;
      end
      RD: if (beat_hs) begin
        beat_d = beat_q + 16'd1;
        if (last_beat) state_d = NEXT;
      end
      NEXT: begin
        beat_d = 16'd0;
        if (last_row && last_tile) begin
          state_d = DONE;
        end else if (last_row) begin
          // next tile restarts one tile column to the right
          tile_d  = tile_q + 8'd1;
          row_d   = 12'd0;
          taddr_d = taddr_q + 32'(au_q);
          raddr_d = taddr_q + 32'(au_q);
          state_d = CMD;
        end else begin
          row_d   = row_q + 12'd1;
          raddr_d = raddr_q + rs_q;
          state_d = CMD;
        end
      end
      DONE: state_d = CFG;
      default: state_d = IDLE;
    endcase
    if (sts_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      widx_q  <= 2'd0;
      chin_q  <= 16'd0;
      wtile_q <= 8'd0;
      imgh_q  <= 12'd0;
      imgw_q  <= 12'd0;
      base_q  <= 32'd0;
      len_q   <= 16'd0;
      au_q    <= 23'd0;
      rs_q    <= 32'd0;
      taddr_q <= 32'd0;
      raddr_q <= 32'd0;
      tile_q  <= 8'd0;
      row_q   <= 12'd0;
      beat_q  <= 16'd0;
      tag_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      chin_q  <= chin_d;
      wtile_q <= wtile_d;
      imgh_q  <= imgh_d;
      imgw_q  <= imgw_d;
      base_q  <= base_d;
      len_q   <= len_d;
      au_q    <= au_d;
      rs_q    <= rs_d;
      taddr_q <= taddr_d;
      raddr_q <= raddr_d;
      tile_q  <= tile_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

endmodule
